// File: rtl/mpe_pkg.sv
// Shared types and helpers for the MPE digit-serial multiply-accumulate array.
package mpe_pkg;

  localparam int IN_BITS_DEF  = 8;
  localparam int W_BITS_DEF   = 8;
  localparam int ACC_BITS_DEF = 24;
  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int DIGIT_DEF    = 1;

  // Widest weight the magnitude helper can handle; callers zero-extend into it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } mpe_state_t;

  typedef struct packed {
    logic [MAX_W-1:0] mag;
    logic             neg;
  } mag_neg_t;

  // Magnitude is taken modulo 2^wbits so the most negative weight maps onto itself.
  function automatic mag_neg_t weight_mag(input logic [MAX_W-1:0] w,
                                          input int unsigned      wbits,
                                          input logic             is_signed);
    mag_neg_t         r;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] sh;
    mask  = (MAX_W'(1) << wbits) - MAX_W'(1);
    sh    = w >> (wbits - 1);
    r.neg = is_signed & sh[0];
    r.mag = (r.neg ? (~w + MAX_W'(1)) : w) & mask;
    return r;
  endfunction

endpackage

// File: rtl/mpe_lane.sv
// One lane of the array: activation shift register plus accumulator with a
// DIGIT-bit multiply-add per RUN cycle.
module mpe_lane
  import mpe_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int ACC_BITS = ACC_BITS_DEF,
  parameter int DIGIT    = DIGIT_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic                clear,
  input  logic                signed_mode,
  input  logic [IN_BITS-1:0]  act,
  input  logic                step,
  input  logic                negate,
  input  logic [DIGIT-1:0]    digit,
  output logic [ACC_BITS-1:0] acc_next,
  output logic [ACC_BITS-1:0] acc
);

  logic [ACC_BITS-1:0] shift_q, shift_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [ACC_BITS-1:0] prod;

  always_comb begin
    prod     = shift_q * {{(ACC_BITS-DIGIT){1'b0}}, digit};
    acc_next = negate ? (acc_q - prod) : (acc_q + prod);
    shift_d  = shift_q;
    acc_d    = acc_q;
    if (load) begin
      shift_d = {{(ACC_BITS-IN_BITS){signed_mode & act[IN_BITS-1]}}, act};
      if (clear) acc_d = '0;
    end else if (step) begin
      shift_d = shift_q << DIGIT;
      acc_d   = acc_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      acc_q   <= '0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mpe_digit_multiplier.sv
// Digit-serial weight x tile multiply-accumulate: FSM, weight magnitude register
// and output snapshot; the per-lane arithmetic lives in mpe_lane.
module mpe_digit_multiplier
  import mpe_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int W_BITS   = W_BITS_DEF,
  parameter int ACC_BITS = ACC_BITS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int DIGIT    = DIGIT_DEF
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W_BITS-1:0]                 weight_val,
  input  logic                              weight_signed,
  input  logic                              acc_clear,
  input  logic [ROWS*COLS*IN_BITS-1:0]      input_vals,
  output logic [ROWS*COLS*ACC_BITS-1:0]     out_vals,
  output logic                              out_valid,
  input  logic                              out_ready,
  output mpe_state_t                        dbg_state
);

  localparam int LANES = ROWS * COLS;

  mpe_state_t                  state_q, state_d;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic                        neg_q, neg_d;
  logic [W_BITS-1:0]           mag_q, mag_d, mag_rem;
  logic [LANES*ACC_BITS-1:0]   out_vals_q, out_vals_d;
  logic [LANES*ACC_BITS-1:0]   acc_all, acc_next_all;
  logic [MAX_W-1:0]            w_ext;
  mag_neg_t                    wm;
  logic                        unused_mag_hi;
  logic                        accept, step, commit, slot_free;

  always_comb begin
    w_ext               = '0;
    w_ext[W_BITS-1:0]   = weight_val;
  end

  assign wm            = weight_mag(w_ext, W_BITS, weight_signed);
  assign unused_mag_hi = |wm.mag[MAX_W-1:W_BITS];

  assign accept    = in_valid && in_ready_q;
  assign step      = (state_q == RUN);
  assign mag_rem   = mag_q >> DIGIT;
  assign commit    = step && (mag_rem == '0);
  assign slot_free = !out_valid_q || out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mpe_lane #(
      .IN_BITS (IN_BITS),
      .ACC_BITS(ACC_BITS),
      .DIGIT   (DIGIT)
    ) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (accept),
      .clear      (acc_clear),
      .signed_mode(weight_signed),
      .act        (input_vals[i*IN_BITS +: IN_BITS]),
      .step       (step),
      .negate     (neg_q),
      .digit      (mag_q[DIGIT-1:0]),
      .acc_next   (acc_next_all[i*ACC_BITS +: ACC_BITS]),
      .acc        (acc_all[i*ACC_BITS +: ACC_BITS])
    );
  end

  // A consume and a commit on the same edge leave out_valid set with the new snapshot.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    out_vals_d  = out_vals_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mag_d   = wm.mag[W_BITS-1:0];
          neg_d   = wm.neg;
          state_d = RUN;
        end
      end
      RUN: begin
        mag_d = mag_rem;
        if (commit) begin
          if (slot_free) begin
            out_vals_d  = acc_next_all;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (out_ready) begin
          out_vals_d  = acc_all;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      mag_q       <= '0;
      out_vals_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      neg_q       <= neg_d;
      mag_q       <= mag_d;
      out_vals_q  <= out_vals_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_vals  = out_vals_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mpe_digit_multiplier.sv
// Bench for mpe_digit_multiplier: a DIGIT=1 and a DIGIT=4 instance (2x2 tile),
// checked against a whole-product accumulate model and directed literals.
module tb_mpe_digit_multiplier;
  import mpe_pkg::*;

  localparam int VW = 96;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0]         in_valid, in_ready, weight_signed, acc_clear, out_valid, out_ready;
  logic [1:0][7:0]    weight_val;
  logic [1:0][31:0]   input_vals;
  logic [1:0][VW-1:0] out_vals;
  mpe_state_t         st0, st1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] exp_q0[$];
  logic [VW-1:0] exp_q1[$];
  logic [23:0]   m_acc [2][4];
  logic          rand_on = 1'b0;

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mpe_digit_multiplier #(
    .IN_BITS(8), .W_BITS(8), .ACC_BITS(24), .ROWS(2), .COLS(2), .DIGIT(1)
  ) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .weight_val(weight_val[0]), .weight_signed(weight_signed[0]), .acc_clear(acc_clear[0]),
    .input_vals(input_vals[0]), .out_vals(out_vals[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dbg_state(st0)
  );

  mpe_digit_multiplier #(
    .IN_BITS(8), .W_BITS(8), .ACC_BITS(24), .ROWS(2), .COLS(2), .DIGIT(4)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .weight_val(weight_val[1]), .weight_signed(weight_signed[1]), .acc_clear(acc_clear[1]),
    .input_vals(input_vals[1]), .out_vals(out_vals[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dbg_state(st1)
  );

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [1:0] st_of(input int id);
    return (id == 0) ? st0 : st1;
  endfunction

  function automatic int model_k(input logic [7:0] w, input logic s, input int dig);
    logic [7:0] mag;
    int top;
    mag = (s && w[7]) ? 8'(8'd0 - w) : w;
    top = 0;
    for (int b = 0; b < 8; b++) if (mag[b]) top = b + 1;
    return (top == 0) ? 1 : (top + dig - 1) / dig;
  endfunction

  // driver: offer one job, update the model, optionally measure the RUN length
  task automatic run_job(input int id, input logic [7:0] w, input logic s, input logic clr,
                         input logic [31:0] vals, input int exp_k, output logic [VW-1:0] exp_v);
    int n;
    logic [23:0] a, wv;
    exp_v = '0;
    n = 0;
    while (!in_ready[id] && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready[id]) begin
      fail_now($sformatf("dut%0d_accept", id));
      return;
    end
    in_valid[id]      = 1'b1;
    weight_val[id]    = w;
    weight_signed[id] = s;
    acc_clear[id]     = clr;
    input_vals[id]    = vals;
    @(posedge clock); #1;
    in_valid[id]      = 1'b0;
    weight_val[id]    = 8'($urandom);
    weight_signed[id] = 1'($urandom);
    acc_clear[id]     = 1'($urandom);
    input_vals[id]    = $urandom;
    wv = s ? {{16{w[7]}}, w} : {16'd0, w};
    for (int l = 0; l < 4; l++) begin
      a = s ? {{16{vals[l*8+7]}}, vals[l*8 +: 8]} : {16'd0, vals[l*8 +: 8]};
      m_acc[id][l] = (clr ? 24'd0 : m_acc[id][l]) + a * wv;
      exp_v[l*24 +: 24] = m_acc[id][l];
    end
    if (id == 0) exp_q0.push_back(exp_v);
    else         exp_q1.push_back(exp_v);
    if (exp_k > 0) begin
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
      end while (!in_ready[id] && n < 40);
      chk($sformatf("dut%0d_run_cycles", id), VW'(n), VW'(exp_k));
    end
  endtask

  task automatic bp_test(input int id, input logic [7:0] w1, input int k1, input logic [VW-1:0] lit1);
    logic [VW-1:0] ev1, ev2, lit2;
    lit2 = {24'd24, 24'd21, 24'd18, 24'd15};
    @(posedge clock); #1;
    out_ready[id] = 1'b0;
    run_job(id, w1, 1'b0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, k1, ev1);
    chk($sformatf("dut%0d_bp_model1", id), ev1, lit1);
    chk($sformatf("dut%0d_bp_first", id), out_vals[id], lit1);
    run_job(id, 8'd3, 1'b0, 1'b1, {8'd8, 8'd7, 8'd6, 8'd5}, -1, ev2);
    repeat (6) @(posedge clock);
    #1;
    chk($sformatf("dut%0d_bp_in_ready", id), VW'(in_ready[id]), '0);
    chk($sformatf("dut%0d_bp_state", id), VW'(st_of(id)), VW'(WAIT));
    chk($sformatf("dut%0d_bp_valid", id), VW'(out_valid[id]), VW'(1));
    chk($sformatf("dut%0d_bp_held", id), out_vals[id], lit1);
    out_ready[id] = 1'b1;
    @(posedge clock); #1;
    chk($sformatf("dut%0d_bp_second", id), out_vals[id], lit2);
    chk($sformatf("dut%0d_bp_valid2", id), VW'(out_valid[id]), VW'(1));
    chk($sformatf("dut%0d_bp_ready2", id), VW'(in_ready[id]), VW'(1));
  endtask

  task automatic rand_jobs(input int id);
    logic [VW-1:0] ev;
    for (int j = 0; j < 25; j++) begin
      run_job(id, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              $urandom, -1, ev);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
  endtask

  // scoreboard: every consumed snapshot must match the model, held ones must not move
  initial begin
    logic [1:0]         pv, pr;
    logic [1:0][VW-1:0] pvals;
    logic [VW-1:0]      e;
    pv = '0;
    pr = '0;
    pvals = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv = '0;
        pr = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (pv[i] && !pr[i]) begin
            chk($sformatf("dut%0d_hold_valid", i), VW'(out_valid[i]), VW'(1));
            chk($sformatf("dut%0d_hold_vals", i), out_vals[i], pvals[i]);
          end
          if (out_valid[i] && out_ready[i]) begin
            if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL dut%0d_unexpected_output: got %h expected no snapshot", i, out_vals[i]);
            end else begin
              e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk($sformatf("dut%0d_snapshot", i), out_vals[i], e);
            end
          end
          pv[i] = out_valid[i];
          pr[i] = out_ready[i];
          pvals[i] = out_vals[i];
        end
      end
    end
  end

  initial begin
    logic [VW-1:0] ev;
    int n;
    in_valid = '0;
    out_ready = '1;
    weight_val = '0;
    weight_signed = '0;
    acc_clear = '0;
    input_vals = '0;
    for (int i = 0; i < 2; i++) for (int l = 0; l < 4; l++) m_acc[i][l] = '0;

    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d_reset_in_ready", i), VW'(in_ready[i]), '0);
      chk($sformatf("dut%0d_reset_out_valid", i), VW'(out_valid[i]), '0);
      chk($sformatf("dut%0d_reset_out_vals", i), out_vals[i], '0);
      chk($sformatf("dut%0d_reset_state", i), VW'(st_of(i)), VW'(IDLE));
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("in_ready_after_reset", VW'(in_ready), VW'(2'b11));

    chk("model_k_signed_min", VW'(model_k(8'h80, 1'b1, 1)), VW'(8));
    chk("model_k_digit4", VW'(model_k(8'hF1, 1'b0, 4)), VW'(2));

    run_job(0, 8'h05, 1'b0, 1'b1, {8'd0, 8'd255, 8'd10, 8'd3}, 3, ev);
    chk("unsigned_model", ev, {24'd0, 24'd1275, 24'd50, 24'd15});
    chk("unsigned_valid", VW'(out_valid[0]), VW'(1));
    chk("unsigned_vals", out_vals[0], {24'd0, 24'd1275, 24'd50, 24'd15});

    run_job(0, 8'h80, 1'b1, 1'b1, {8'h80, 8'h7F, 8'h01, 8'hFF}, 8, ev);
    chk("signed_model", ev, {24'h004000, 24'hFFC080, 24'hFFFF80, 24'h000080});
    chk("signed_vals", out_vals[0], {24'h004000, 24'hFFC080, 24'hFFFF80, 24'h000080});

    run_job(0, 8'd2, 1'b0, 1'b1, {4{8'd7}}, 2, ev);
    run_job(0, 8'd3, 1'b0, 1'b0, {4{8'd1}}, 2, ev);
    chk("chain_model", ev, {4{24'd17}});
    chk("chain_vals", out_vals[0], {4{24'd17}});

    run_job(0, 8'd0, 1'b0, 1'b0, $urandom, 1, ev);
    chk("zero_keep_vals", out_vals[0], {4{24'd17}});
    run_job(0, 8'd0, 1'b1, 1'b1, $urandom, 1, ev);
    chk("zero_clear_vals", out_vals[0], '0);

    bp_test(0, 8'h11, 5, {24'd68, 24'd51, 24'd34, 24'd17});
    bp_test(1, 8'hF1, 2, {24'd964, 24'd723, 24'd482, 24'd241});

    @(posedge clock); #1;
    @(posedge clock); #1;
    run_job(0, 8'h2B, 1'b0, 1'b1, $urandom, -1, ev);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    void'(exp_q0.pop_back());
    for (int i = 0; i < 2; i++) for (int l = 0; l < 4; l++) m_acc[i][l] = '0;
    #1;
    chk("abort_out_valid", VW'(out_valid[0]), '0);
    chk("abort_out_vals", out_vals[0], '0);
    chk("abort_state", VW'(st0), VW'(IDLE));
    chk("abort_in_ready", VW'(in_ready[0]), '0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_job(0, 8'd3, 1'b0, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 2, ev);
    chk("after_reset_vals", out_vals[0], {24'd12, 24'd9, 24'd6, 24'd3});

    rand_on = 1'b1;
    fork
      begin
        fork
          rand_jobs(0);
          rand_jobs(1);
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clock); #1;
          if (rand_on) begin
            out_ready[0] = ($urandom_range(0, 3) != 0);
            out_ready[1] = ($urandom_range(0, 3) != 0);
          end
        end
      end
    join

    out_ready = '1;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_pending", VW'(exp_q0.size() + exp_q1.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
